// File: rtl/rf_pkg.sv
// Shared types and default sizing for the multi-port register file.
package rf_pkg;

   localparam int RF_DW    = 16;
   localparam int RF_DEPTH = 16;

   typedef enum logic {
      RF_IDLE  = 1'b0,
      RF_CLEAR = 1'b1
   } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set by issue, cleared by writeback, bulk-cleared by the sequencer.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int DEPTH    = RF_DEPTH,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   parameter int AW       = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_set_en,
   input  logic [AW-1:0]     i_set_addr,
   input  logic              i_clr_a_en,
   input  logic [AW-1:0]     i_clr_a_addr,
   input  logic              i_clr_b_en,
   input  logic [AW-1:0]     i_clr_b_addr,
   input  logic              i_clr_all,
   input  logic [NRD*AW-1:0] i_rd_addr,
   output logic [NRD-1:0]    o_rd_pend
);

   logic [DEPTH-1:0] r_pend;
   logic [DEPTH-1:0] w_pend_nxt;

   // Set is applied after the clears: a newer producer has issued for that register.
   always_comb begin
      w_pend_nxt = r_pend;
      if (i_clr_all) begin
         w_pend_nxt = '0;
      end else begin
         if (i_clr_a_en) w_pend_nxt[i_clr_a_addr] = 1'b0;
         if (i_clr_b_en) w_pend_nxt[i_clr_b_addr] = 1'b0;
         if (i_set_en)   w_pend_nxt[i_set_addr]   = 1'b1;
      end
      if (ZERO_REG != 0) w_pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_pend <= '0;
      else      r_pend <= w_pend_nxt;
   end

   always_comb begin
      o_rd_pend = '0;
      for (int i = 0; i < NRD; i++) begin
         o_rd_pend[i] = r_pend[i_rd_addr[i*AW +: AW]];
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: general + link write ports, zero register, bypass,
// hazard scoreboard and a DEPTH-cycle bulk-clear sequencer.
module reg_file_mp
   import rf_pkg::*;
#(
   parameter int DW       = RF_DW,
   parameter int DEPTH    = RF_DEPTH,
   parameter int AW       = $clog2(DEPTH),
   parameter int NRD      = 2,
   parameter int LINK_IDX = DEPTH - 1,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD*DW-1:0] rd_data,
   output logic [NRD-1:0]    rd_pend,
   input  logic              w_en,
   input  logic [AW-1:0]     w_addr,
   input  logic [DW-1:0]     w_data,
   input  logic              lr_we,
   input  logic [DW-1:0]     lr_data,
   output logic [DW-1:0]     lr_out,
   input  logic              sb_set,
   input  logic [AW-1:0]     sb_addr,
   input  logic              clr_req,
   output logic              busy
);

   localparam logic [AW-1:0] LINK_A = AW'(LINK_IDX);
   localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);

   logic [DW-1:0] r_regs [DEPTH];
   rf_state_e     r_state;
   logic [AW-1:0] r_idx;
   logic          r_busy;

   logic w_idle;
   logic w_gen_we;
   logic w_lr_we;
   logic w_clr_last;

   assign w_idle     = (r_state == RF_IDLE);
   assign w_gen_we   = w_idle && w_en && !((ZERO_REG != 0) && (w_addr == '0));
   assign w_lr_we    = w_idle && lr_we && !((ZERO_REG != 0) && (LINK_A == '0));
   assign w_clr_last = (r_state == RF_CLEAR) && (r_idx == LAST_A);
   assign busy       = r_busy;

   // Link write is issued after the general write so it wins a collision on LINK_IDX.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
         r_state <= RF_IDLE;
         r_idx   <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            RF_IDLE: begin
               if (w_gen_we) r_regs[w_addr] <= w_data;
               if (w_lr_we)  r_regs[LINK_A] <= lr_data;
               if (clr_req) begin
                  r_state <= RF_CLEAR;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            RF_CLEAR: begin
               r_regs[r_idx] <= '0;
               r_idx         <= r_idx + 1'b1;
               if (r_idx == LAST_A) begin
                  r_state <= RF_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= RF_IDLE;
         endcase
      end
   end

   function automatic logic [DW-1:0] f_read(input logic [AW-1:0] a);
      if ((ZERO_REG != 0) && (a == '0))                   return '0;
      if ((BYPASS != 0) && w_lr_we && (a == LINK_A))       return lr_data;
      if ((BYPASS != 0) && w_idle && w_en && (a == w_addr)) return w_data;
      return r_regs[a];
   endfunction

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NRD; i++) begin
         rd_data[i*DW +: DW] = f_read(rd_addr[i*AW +: AW]);
      end
      lr_out = f_read(LINK_A);
   end

   rf_scoreboard #(
      .DEPTH    (DEPTH),
      .NRD      (NRD),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
   ) u_sb (
      .clk          (clk),
      .rst          (rst),
      .i_set_en     (w_idle && sb_set),
      .i_set_addr   (sb_addr),
      .i_clr_a_en   (w_idle && w_en),
      .i_clr_a_addr (w_addr),
      .i_clr_b_en   (w_idle && lr_we),
      .i_clr_b_addr (LINK_A),
      .i_clr_all    (w_clr_last),
      .i_rd_addr    (rd_addr),
      .o_rd_pend    (rd_pend)
   );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and randomized checks of reg_file_mp against an array-based reference model.
module tb_reg_file_mp;

   localparam int DW = 16, DEPTH = 16, AW = 4, NRD = 2, LINK = 15;

   logic              clk = 1'b0;
   logic              rst;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*DW-1:0] rd_data;
   logic [NRD-1:0]    rd_pend;
   logic              w_en, lr_we, sb_set, clr_req;
   logic [AW-1:0]     w_addr, sb_addr;
   logic [DW-1:0]     w_data, lr_data, lr_out;
   logic              busy;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] m_reg [DEPTH];
   logic          m_pend [DEPTH];
   int            m_clr_left;

   always #5 clk = ~clk;

   reg_file_mp dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
      .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .lr_we(lr_we), .lr_data(lr_data),
      .lr_out(lr_out), .sb_set(sb_set), .sb_addr(sb_addr), .clr_req(clr_req), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      w_en = 0; w_addr = '0; w_data = '0; lr_we = 0; lr_data = '0;
      sb_set = 0; sb_addr = '0; clr_req = 0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_reg[i] = '0;
         m_pend[i] = 1'b0;
      end
      m_clr_left = 0;
   endtask

   // Value a read of register a should return this cycle.
   function automatic logic [DW-1:0] exp_rd(input int a);
      if (a == 0) return '0;
      if (m_clr_left == 0 && lr_we && a == LINK) return lr_data;
      if (m_clr_left == 0 && w_en && a == int'(w_addr)) return w_data;
      return m_reg[a];
   endfunction

   task automatic model_step();
      if (m_clr_left > 0) begin
         m_reg[DEPTH - m_clr_left] = '0;
         m_clr_left--;
         if (m_clr_left == 0)
            for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
      end else begin
         if (w_en && w_addr != 0) m_reg[w_addr] = w_data;
         if (lr_we) m_reg[LINK] = lr_data;
         if (w_en) m_pend[w_addr] = 1'b0;
         if (lr_we) m_pend[LINK] = 1'b0;
         if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
         if (clr_req) m_clr_left = DEPTH;
      end
   endtask

   task automatic check_outputs();
      for (int p = 0; p < NRD; p++) begin
         chk("rd_data", 32'(rd_data[p*DW +: DW]), 32'(exp_rd(int'(rd_addr[p*AW +: AW]))));
         chk("rd_pend", 32'(rd_pend[p]), 32'(m_pend[rd_addr[p*AW +: AW]]));
      end
      chk("lr_out", 32'(lr_out), 32'(exp_rd(LINK)));
      chk("busy", 32'(busy), 32'(m_clr_left > 0));
   endtask

   // Entered just after a falling edge with inputs already driven.
   task automatic cycle();
      #1;
      check_outputs();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic random_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         rd_addr = AW*NRD'($urandom);
         w_en = 1'($urandom_range(0, 1)); w_addr = AW'($urandom); w_data = DW'($urandom);
         lr_we = ($urandom_range(0, 3) == 0); lr_data = DW'($urandom);
         sb_set = 1'($urandom_range(0, 1)); sb_addr = AW'($urandom);
         clr_req = ($urandom_range(0, 59) == 0);
         cycle();
      end
      idle_inputs();
   endtask

   task automatic read_all();
      idle_inputs();
      for (int a = 0; a < DEPTH; a += 2) begin
         rd_addr = {AW'(a + 1), AW'(a)};
         cycle();
      end
   endtask

   initial begin
      int busy_cnt;
      idle_inputs();
      rd_addr = '0;
      @(negedge clk);
      apply_reset();

      // Reset in the middle of random traffic, then sweep all registers.
      random_cycles(30);
      apply_reset();
      chk("rst_busy", 32'(busy), 32'd0);
      read_all();

      // Same-cycle write bypass, then stored value.
      w_en = 1; w_addr = 4'd3; w_data = 16'hff0f; rd_addr = {4'd0, 4'd3};
      #1 chk("bypass_r3", 32'(rd_data[15:0]), 32'hff0f);
      cycle();
      idle_inputs();
      #1 chk("stored_r3", 32'(rd_data[15:0]), 32'hff0f);
      cycle();

      // Link port beats general port on LINK_IDX; register 0 stays zero.
      w_en = 1; w_addr = 4'd15; w_data = 16'h1111; lr_we = 1; lr_data = 16'h2222;
      rd_addr = {4'd15, 4'd15};
      #1 chk("lr_bypass", 32'(lr_out), 32'h2222);
      cycle();
      idle_inputs();
      #1 chk("lr_stored", 32'(rd_data[31:16]), 32'h2222);
      cycle();
      w_en = 1; w_addr = 4'd0; w_data = 16'h5555; rd_addr = {4'd0, 4'd0};
      cycle();
      idle_inputs();
      #1 chk("zero_reg", 32'(rd_data[15:0]), 32'h0);
      cycle();

      // Scoreboard set/clear priority.
      sb_set = 1; sb_addr = 4'd5; rd_addr = {4'd5, 4'd5};
      cycle();
      idle_inputs();
      #1 chk("pend_set", 32'(rd_pend[0]), 32'd1);
      w_en = 1; w_addr = 4'd5; w_data = 16'h0505; sb_set = 1; sb_addr = 4'd5;
      cycle();
      idle_inputs();
      #1 chk("pend_set_wins", 32'(rd_pend[1]), 32'd1);
      w_en = 1; w_addr = 4'd5; w_data = 16'h0506;
      cycle();
      idle_inputs();
      #1 chk("pend_cleared", 32'(rd_pend[0]), 32'd0);
      cycle();

      // Bulk clear: fill, mark some pending, pulse, count busy cycles.
      for (int a = 1; a < DEPTH; a++) begin
         w_en = 1; w_addr = AW'(a); w_data = DW'(16'h1000 + a);
         sb_set = 1; sb_addr = AW'(DEPTH - a);
         cycle();
      end
      idle_inputs();
      clr_req = 1;
      cycle();
      clr_req = 0;
      busy_cnt = 0;
      for (int k = 0; k < 40 && busy; k++) begin
         busy_cnt++;
         idle_inputs();
         if (k == 3) begin
            w_en = 1; w_addr = 4'd2; w_data = 16'hbeef; sb_set = 1; sb_addr = 4'd6;
         end
         rd_addr = {4'd2, 4'd6};
         cycle();
      end
      idle_inputs();
      chk("busy_len", 32'(busy_cnt), 32'd16);
      read_all();
      rd_addr = {4'd6, 4'd2};
      #1 chk("clr_r2", 32'(rd_data[15:0]), 32'h0);
      chk("clr_pend6", 32'(rd_pend[1]), 32'd0);

      // Reset aborts an in-progress clear.
      for (int a = 1; a < DEPTH; a++) begin
         w_en = 1; w_addr = AW'(a); w_data = DW'($urandom_range(1, 16'hffff));
         cycle();
      end
      idle_inputs();
      clr_req = 1;
      cycle();
      clr_req = 0;
      repeat (7) cycle();
      rst = 1'b0;
      model_reset();
      #1 chk("abort_busy", 32'(busy), 32'd0);
      check_outputs();
      @(negedge clk);
      rst = 1'b1;
      w_en = 1; w_addr = 4'd4; w_data = 16'h0040;
      cycle();
      idle_inputs();
      rd_addr = {4'd0, 4'd4};
      #1 chk("post_abort_w4", 32'(rd_data[15:0]), 32'h0040);
      cycle();

      random_cycles(500);
      read_all();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
